// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bip_pkg
// Brief    : Shared opcode, sel_a and FSM encodings for the BIP processor.
// Revision : 1.0 - initial release
// ============================================================================
package bip_pkg;

  localparam int NB_OPC = 5;

  // Opcode field values (instruction bits [15:11])
  localparam logic [NB_OPC-1:0] OPC_HLT  = 5'b00000;
  localparam logic [NB_OPC-1:0] OPC_STO  = 5'b00001;
  localparam logic [NB_OPC-1:0] OPC_LD   = 5'b00010;
  localparam logic [NB_OPC-1:0] OPC_LDI  = 5'b00011;
  localparam logic [NB_OPC-1:0] OPC_ADD  = 5'b00100;
  localparam logic [NB_OPC-1:0] OPC_ADDI = 5'b00101;
  localparam logic [NB_OPC-1:0] OPC_SUB  = 5'b00110;
  localparam logic [NB_OPC-1:0] OPC_SUBI = 5'b00111;

  // Accumulator source select, shared with the datapath
  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // Decoded control bundle
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_code;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/bip_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bip_decoder
// Brief    : Combinational opcode-to-control mapping for the BIP processor.
// Revision : 1.0 - initial release
// ============================================================================
module bip_decoder
  import bip_pkg::*;
(
  input  logic [NB_OPC-1:0] i_opcode,
  output ctrl_t             o_ctrl,
  output logic              o_is_hlt
);

  // Map each opcode to its datapath / data-memory controls; unknown opcodes are NOPs
  always_comb begin
    o_ctrl   = CTRL_NONE;
    o_is_hlt = 1'b0;
    case (i_opcode)
      OPC_HLT: o_is_hlt = 1'b1;
      OPC_STO: o_ctrl.wr_ram = 1'b1;
      OPC_LD: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_MEM;
      end
      OPC_LDI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_IMM;
      end
      OPC_ADD: begin
        o_ctrl.rd_ram  = 1'b1;
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SELA_ALU;
        o_ctrl.op_code = 1'b1;
      end
      OPC_ADDI: begin
        o_ctrl.wr_acc  = 1'b1;
        o_ctrl.sel_a   = SELA_ALU;
        o_ctrl.sel_b   = 1'b1;
        o_ctrl.op_code = 1'b1;
      end
      OPC_SUB: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
      end
      OPC_SUBI: begin
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.sel_a  = SELA_ALU;
        o_ctrl.sel_b  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : bip_control_unit
// Brief    : BIP fetch/decode/sequencing stage: PC, start/halt FSM, decode
//            gating and RUN-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int NB_BITS   = 16,
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = NB_BITS - NB_OPCODE,
  parameter int NB_CNT    = 32,
  parameter int NB_SELA   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_instr,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_data_ins,
  output logic [NB_SELA-1:0] o_sel_a,
  output logic               o_sel_b,
  output logic               o_op_code,
  output logic               o_wr_acc,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_rd_ram,
  output logic               o_wr_ram,
  output logic               o_halt,
  output logic               o_busy,
  output logic [NB_CNT-1:0]  o_cycles
);

  localparam logic [NB_CNT-1:0] c_CNT_MAX = '1;

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_ADDR-1:0] r_pc;
  logic [NB_CNT-1:0]  r_cycles;
  ctrl_t              w_dec;
  logic               w_is_hlt;
  logic               w_run;

  bip_decoder u_decoder (
    .i_opcode (i_instr[NB_BITS-1 -: NB_OPCODE]),
    .o_ctrl   (w_dec),
    .o_is_hlt (w_is_hlt)
  );

  assign w_run = (r_state == ST_RUN);

  // State register; reset drops out of RUN at once so every enable falls immediately
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: start leaves IDLE, HLT leaves RUN, HALT only exits through reset
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_start)  w_next_state = ST_RUN;
      ST_RUN:  if (w_is_hlt) w_next_state = ST_HALT;
      default: w_next_state = r_state;
    endcase
  end

  // PC advances (with natural wrap) on every RUN cycle except HLT; counter saturates
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc     <= '0;
      r_cycles <= '0;
    end else if (w_run) begin
      if (!w_is_hlt)              r_pc     <= r_pc + 1'b1;
      if (r_cycles != c_CNT_MAX)  r_cycles <= r_cycles + 1'b1;
    end
  end

  // Controls are only live in RUN; operand field passes through unconditionally
  assign o_sel_a    = w_run ? NB_SELA'(w_dec.sel_a) : '0;
  assign o_sel_b    = w_run & w_dec.sel_b;
  assign o_op_code  = w_run & w_dec.op_code;
  assign o_wr_acc   = w_run & w_dec.wr_acc;
  assign o_rd_ram   = w_run & w_dec.rd_ram;
  assign o_wr_ram   = w_run & w_dec.wr_ram;
  assign o_data_ins = i_instr[NB_ADDR-1:0];
  assign o_addr     = i_instr[NB_ADDR-1:0];
  assign o_pc       = r_pc;
  assign o_cycles   = r_cycles;
  assign o_busy     = w_run;
  assign o_halt     = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bip_control_unit
// Brief    : Self-checking bench for bip_control_unit (vectors + reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bip_control_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_instr;
  logic [10:0] o_pc, o_data_ins, o_addr;
  logic [1:0]  o_sel_a;
  logic        o_sel_b, o_op_code, o_wr_acc, o_rd_ram, o_wr_ram, o_halt, o_busy;
  logic [31:0] o_cycles;

  bip_control_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .o_pc(o_pc), .o_data_ins(o_data_ins), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
    .o_op_code(o_op_code), .o_wr_acc(o_wr_acc), .o_addr(o_addr),
    .o_rd_ram(o_rd_ram), .o_wr_ram(o_wr_ram), .o_halt(o_halt), .o_busy(o_busy),
    .o_cycles(o_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Asynchronous-read program memory, or a forced instruction word
  logic [15:0] mem [2048];
  logic        use_mem;
  logic [15:0] instr_force;
  assign i_instr = use_mem ? mem[o_pc] : instr_force;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       rd;
    logic       wr;
  } ctl_t;

  typedef struct {
    logic [15:0] instr;
    logic [10:0] pc;
    ctl_t        c;
  } vec_t;

  ctl_t tab [32];
  vec_t vecs [6];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: 0 idle, 1 run, 2 halt
  int          m_state;
  int          m_pc;
  longint      m_cycles;

  function automatic ctl_t mk(input logic [1:0] sa, input logic sb, input logic op,
                              input logic wa, input logic rd, input logic wr);
    ctl_t c;
    c.sel_a = sa; c.sel_b = sb; c.op = op; c.wr_acc = wa; c.rd = rd; c.wr = wr;
    return c;
  endfunction

  function automatic logic [15:0] model_instr();
    return use_mem ? mem[m_pc] : instr_force;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cycles = 0;
  endtask

  task automatic model_step(input logic [15:0] ins, input logic st);
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (ins[15:11] == 5'd0) m_state = 2;
        else                    m_pc = (m_pc + 1) % 2048;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] ins;
    ctl_t e;
    ins = model_instr();
    e = (m_state == 1) ? tab[ins[15:11]] : ctl_t'(0);
    chk("pc",       o_pc,       m_pc);
    chk("data_ins", o_data_ins, ins[10:0]);
    chk("addr",     o_addr,     ins[10:0]);
    chk("sel_a",    o_sel_a,    e.sel_a);
    chk("sel_b",    o_sel_b,    e.sel_b);
    chk("op_code",  o_op_code,  e.op);
    chk("wr_acc",   o_wr_acc,   e.wr_acc);
    chk("rd_ram",   o_rd_ram,   e.rd);
    chk("wr_ram",   o_wr_ram,   e.wr);
    chk("busy",     o_busy,     m_state == 1);
    chk("halt",     o_halt,     m_state == 2);
    chk("cycles",   o_cycles,   m_cycles);
  endtask

  // One clock: capture pre-edge inputs, step model, land on the next falling edge
  task automatic cycle();
    logic [15:0] ins;
    logic st, rs;
    ins = model_instr(); st = i_start; rs = i_rst;
    @(posedge i_clk);
    if (rs) model_step(ins, st);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_start = 1'b0;
    model_reset();
    cycle(); cycle();
    i_rst = 1'b1;
    cycle();
  endtask

  task automatic start_run();
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic check_vec(input int i);
    chk($sformatf("v%0d_pc", i),     o_pc,       vecs[i].pc);
    chk($sformatf("v%0d_sel_a", i),  o_sel_a,    vecs[i].c.sel_a);
    chk($sformatf("v%0d_sel_b", i),  o_sel_b,    vecs[i].c.sel_b);
    chk($sformatf("v%0d_op", i),     o_op_code,  vecs[i].c.op);
    chk($sformatf("v%0d_wr_acc", i), o_wr_acc,   vecs[i].c.wr_acc);
    chk($sformatf("v%0d_rd", i),     o_rd_ram,   vecs[i].c.rd);
    chk($sformatf("v%0d_wr", i),     o_wr_ram,   vecs[i].c.wr);
    chk($sformatf("v%0d_opnd", i),   o_data_ins, vecs[i].instr[10:0]);
    chk($sformatf("v%0d_addr", i),   o_addr,     vecs[i].instr[10:0]);
  endtask

  initial begin
    logic seen_en;
    logic [4:0] op;

    i_rst = 1'b0; i_start = 1'b0; use_mem = 1'b1; instr_force = 16'h0000;
    model_reset();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 32; i++) tab[i] = ctl_t'(0);
    tab[1] = mk(2'b00, 0, 0, 0, 0, 1);
    tab[2] = mk(2'b00, 0, 0, 1, 1, 0);
    tab[3] = mk(2'b01, 0, 0, 1, 0, 0);
    tab[4] = mk(2'b10, 0, 1, 1, 1, 0);
    tab[5] = mk(2'b10, 1, 1, 1, 0, 0);
    tab[6] = mk(2'b10, 0, 0, 1, 1, 0);
    tab[7] = mk(2'b10, 1, 0, 1, 0, 0);

    vecs[0] = '{16'h1805, 11'd0, mk(2'b01, 0, 0, 1, 0, 0)};
    vecs[1] = '{16'h2803, 11'd1, mk(2'b10, 1, 1, 1, 0, 0)};
    vecs[2] = '{16'h0810, 11'd2, mk(2'b00, 0, 0, 0, 0, 1)};
    vecs[3] = '{16'h0000, 11'd3, mk(2'b00, 0, 0, 0, 0, 0)};
    vecs[4] = '{16'h17FF, 11'd0, mk(2'b00, 0, 0, 1, 1, 0)};
    vecs[5] = '{16'h3001, 11'd1, mk(2'b10, 0, 0, 1, 1, 0)};

    @(negedge i_clk);

    // Reset and idle with no start
    do_reset();
    for (int i = 0; i < 5; i++) begin cycle(); check_all(); end
    chk("idle_pc", o_pc, 0);
    chk("idle_busy", o_busy, 0);

    // Program run: LDI 5; ADDI 3; STO 0x010; HLT
    for (int i = 0; i < 4; i++) mem[i] = vecs[i].instr;
    start_run();
    for (int i = 0; i < 4; i++) begin
      check_vec(i);
      check_all();
      cycle();
    end
    check_all();
    chk("run_halt", o_halt, 1);
    chk("run_pc", o_pc, 3);
    chk("run_cycles", o_cycles, 4);

    // Halt stickiness: start pulse and a live ADDI are ignored
    use_mem = 1'b0; instr_force = 16'h2801;
    start_run();
    check_all();
    for (int i = 0; i < 3; i++) begin cycle(); check_all(); end
    chk("sticky_pc", o_pc, 3);
    chk("sticky_cycles", o_cycles, 4);
    chk("sticky_wr_acc", o_wr_acc, 0);
    use_mem = 1'b1;

    // Memory operands: LD 0x7FF; SUB 0x001
    do_reset();
    mem[0] = vecs[4].instr; mem[1] = vecs[5].instr; mem[2] = 16'h0000; mem[3] = 16'h0000;
    start_run();
    for (int i = 4; i < 6; i++) begin
      check_vec(i);
      check_all();
      cycle();
    end

    // Async reset between edges while STO is executing
    do_reset();
    mem[0] = 16'h0810;
    start_run();
    chk("sto_wr_before_rst", o_wr_ram, 1);
    #2 i_rst = 1'b0;
    model_reset();
    #1;
    chk("async_wr_ram", o_wr_ram, 0);
    chk("async_pc", o_pc, 0);
    chk("async_cycles", o_cycles, 0);
    chk("async_busy", o_busy, 0);
    @(negedge i_clk);
    check_all();
    i_rst = 1'b1;
    cycle();
    check_all();

    // Wrap-around over an all-NOP program
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800 | 16'(i);
    do_reset();
    start_run();
    seen_en = 1'b0;
    for (int i = 0; i < 2046; i++) begin
      seen_en |= o_wr_acc | o_rd_ram | o_wr_ram;
      cycle();
      check_all();
    end
    chk("wrap_pc_7fe", o_pc, 11'h7FE);
    cycle(); check_all();
    chk("wrap_pc_7ff", o_pc, 11'h7FF);
    cycle(); check_all();
    chk("wrap_pc_000", o_pc, 11'h000);
    seen_en |= o_wr_acc | o_rd_ram | o_wr_ram;
    chk("nop_no_enables", seen_en, 0);

    // Randomized programs, start pulses and resets against the model
    for (int i = 0; i < 2048; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd0 && $urandom_range(0, 7) != 0) op = 5'd3;
      mem[i] = {op, 11'($urandom)};
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      i_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 79) == 0 || (m_state == 2 && $urandom_range(0, 9) == 0)) begin
        i_rst = 1'b0;
        model_reset();
        #1 check_all();
        cycle();
        i_rst = 1'b1;
      end else begin
        cycle();
      end
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
